// File: rtl/pool2_stream_ctrl.sv
// rtl/pool2_stream_ctrl.sv - 2x2 max-pool sequencer for a shift line buffer stream
module pool2_stream_ctrl #(
  parameter int FEATURE_MAP_SIZE = 14,
  parameter int DATA_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buf_en,
  input  logic [DATA_W-1:0] tap1,
  input  logic [DATA_W-1:0] tap2,
  input  logic [DATA_W-1:0] tap3,
  input  logic [DATA_W-1:0] tap4,
  output logic [DATA_W-1:0] pool_data,
  output logic              pool_valid,
  input  logic              pool_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int POS_W     = (FEATURE_MAP_SIZE > 2) ? $clog2(FEATURE_MAP_SIZE) : 1;
  localparam int OUT_TOTAL = (FEATURE_MAP_SIZE / 2) * (FEATURE_MAP_SIZE / 2);
  localparam int CNT_W     = $clog2(OUT_TOTAL + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FEATURE_MAP_SIZE - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state;
  logic [POS_W-1:0]  row;
  logic [POS_W-1:0]  col;
  logic [CNT_W-1:0]  out_cnt;
  logic              pend;
  logic              accept;
  logic              win_pix;
  logic              last_pix;
  logic              out_hs;
  logic [DATA_W-1:0] max_a;
  logic [DATA_W-1:0] max_b;
  logic [DATA_W-1:0] max_all;

  // Stall input while taps are being sampled or an output is stuck downstream.
  assign in_ready = (state == RUN) && !pend && !(pool_valid && !pool_ready);
  assign buf_en   = in_valid & in_ready;
  assign accept   = buf_en;
  assign win_pix  = row[0] & col[0];
  assign last_pix = (row == POS_LAST) && (col == POS_LAST);
  assign out_hs   = pool_valid & pool_ready;

  assign max_a   = (tap1 > tap2) ? tap1 : tap2;
  assign max_b   = (tap3 > tap4) ? tap3 : tap4;
  assign max_all = (max_a > max_b) ? max_a : max_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      out_cnt    <= '0;
      pend       <= 1'b0;
      pool_data  <= '0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pend       <= accept && win_pix;
      frame_done <= 1'b0;

      // A fresh load takes priority over retiring the current output.
      if (pend) begin
        pool_data  <= max_all;
        pool_valid <= 1'b1;
        out_cnt    <= out_cnt + CNT_W'(1);
      end else if (out_hs) begin
        pool_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == POS_LAST) begin
              col <= '0;
              row <= last_pix ? '0 : row + POS_W'(1);
            end else begin
              col <= col + POS_W'(1);
            end
            if (last_pix) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!pend && out_hs && (out_cnt == OUT_LAST)) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
